// File: rtl/luma_to_rgb.sv
// Expands 8-bit luma to 24-bit RGB via a per-frame colour map, tagging start-of-frame and end-of-line.
// Latency: 2 cycles from input transfer to out_valid; throughput 1 pixel/cycle.
// Backpressure: two-stage skid-free pipeline, in_ready = !s1_valid | !s2_valid | out_ready; outputs hold while stalled.
module luma_to_rgb #(
    parameter int H_PIXELS = 640,
    parameter int V_LINES  = 480,
    parameter int THRESH   = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mode,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sof,
    input  logic [7:0]  L,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] RGB,
    output logic        out_sof,
    output logic        out_eol,
    output logic        sync_err
);

    localparam int CW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int RW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(H_PIXELS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(V_LINES - 1);
    localparam logic [7:0]    THR      = 8'(THRESH);

    logic [CW-1:0] col, cur_col;
    logic [RW-1:0] row, cur_row;
    logic [1:0]    frame_mode, pix_mode;
    logic          at_origin, cnt_origin, pix_eol;
    logic          in_xfer, s2_load;

    logic          s1_valid, s1_sof, s1_eol;
    logic [7:0]    s1_l;
    logic [1:0]    s1_mode;
    logic          s2_valid;

    function automatic logic [23:0] map_rgb(input logic [1:0] m, input logic [7:0] l);
        logic [7:0] r, g, b, dbl;
        dbl = {l[6:0], 1'b0};
        r   = 8'h00;
        g   = 8'h00;
        b   = 8'h00;
        case (m)
            2'd0: begin r = l; g = l; b = l; end
            2'd1: begin
                r = (l >= THR) ? 8'hFF : 8'h00;
                g = r;
                b = r;
            end
            2'd2: begin
                if (l[7]) begin r = 8'hFF; g = dbl; b = 8'h00; end
                else      begin r = dbl; g = 8'h00; b = 8'hFF - dbl; end
            end
            default: begin r = 8'hFF - l; g = r; b = r; end
        endcase
        return {b, g, r};
    endfunction

    assign s2_load   = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_load;
    assign in_xfer   = in_valid && in_ready;
    assign out_valid = s2_valid;

    // An in_sof beat is forced to (0,0) regardless of where the counters think we are.
    assign cnt_origin = (col == '0) && (row == '0);
    assign at_origin  = in_sof || cnt_origin;
    assign cur_col    = in_sof ? '0 : col;
    assign cur_row    = in_sof ? '0 : row;
    assign pix_eol    = (cur_col == COL_LAST);
    assign pix_mode   = at_origin ? mode : frame_mode;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col        <= '0;
            row        <= '0;
            frame_mode <= 2'd0;
            sync_err   <= 1'b0;
        end else begin
            sync_err <= in_xfer && in_sof && !cnt_origin;
            if (in_xfer) begin
                if (at_origin) frame_mode <= mode;
                if (pix_eol) begin
                    col <= '0;
                    row <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
                end else begin
                    col <= cur_col + CW'(1);
                    row <= cur_row;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_l     <= 8'h00;
            s1_mode  <= 2'd0;
            s1_sof   <= 1'b0;
            s1_eol   <= 1'b0;
        end else begin
            s1_valid <= in_xfer || (s1_valid && !s2_load);
            if (in_xfer) begin
                s1_l    <= L;
                s1_mode <= pix_mode;
                s1_sof  <= at_origin;
                s1_eol  <= pix_eol;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            RGB      <= 24'h000000;
            out_sof  <= 1'b0;
            out_eol  <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                RGB     <= map_rgb(s1_mode, s1_l);
                out_sof <= s1_sof;
                out_eol <= s1_eol;
            end
        end
    end

endmodule

// File: tb/tb_luma_to_rgb.sv
// Bench for luma_to_rgb on a 4x2 frame: reference model tracks frame position and mode with plain arithmetic.
module tb_luma_to_rgb;

    localparam int H = 4;
    localparam int V = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sof = 1'b0;
    logic [7:0]  L = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] RGB;
    logic        out_sof;
    logic        out_eol;
    logic        sync_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [25:0] exp_q[$];
    int          m_pos;
    int          m_mode;
    bit          pend_sync;

    luma_to_rgb #(.H_PIXELS(H), .V_LINES(V), .THRESH(128)) dut (
        .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_sof(in_sof), .L(L), .out_valid(out_valid), .out_ready(out_ready), .RGB(RGB),
        .out_sof(out_sof), .out_eol(out_eol), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] ref_map(input int m, input int l);
        int r, g, b;
        case (m)
            0: begin r = l; g = l; b = l; end
            1: begin r = (l >= 128) ? 255 : 0; g = r; b = r; end
            2: begin
                if (l < 128) begin r = 2 * l; g = 0; b = 255 - 2 * l; end
                else         begin r = 255; g = 2 * (l - 128); b = 0; end
            end
            default: begin r = 255 - l; g = r; b = r; end
        endcase
        return 24'(b * 65536 + g * 256 + r);
    endfunction

    // One clock of stimulus; the model consumes every accepted beat.
    task automatic cycle(input bit v, input bit sof, input logic [7:0] l, input logic [1:0] md,
                         input bit ordy, output bit ixfer, output bit ovld, output bit oxfer,
                         output logic [25:0] obs, output bit serr, output bit serr_exp);
        int p;
        @(negedge clk);
        in_valid = v; in_sof = sof; L = l; mode = md; out_ready = ordy;
        #1;
        ovld     = out_valid;
        oxfer    = out_valid && out_ready;
        obs      = {out_eol, out_sof, RGB};
        serr     = sync_err;
        serr_exp = pend_sync;
        pend_sync = 1'b0;
        ixfer    = in_valid && in_ready;
        if (ixfer) begin
            p = sof ? 0 : m_pos;
            pend_sync = sof && (m_pos != 0);
            if (p == 0) m_mode = md;
            exp_q.push_back({((p % H) == H - 1), (p == 0), ref_map(m_mode, l)});
            m_pos = (p + 1) % (H * V);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete(); m_pos = 0; m_mode = 0; pend_sync = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk); #1;
        n_tests++;
        if ({out_valid, RGB, out_sof, out_eol, sync_err} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got vld=%b rgb=%h sof=%b eol=%b serr=%b, want all 0",
                     out_valid, RGB, out_sof, out_eol, sync_err);
        end
        do_reset();
        @(negedge clk); #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_gray_latency();
        logic [7:0]  lv[3]  = '{8'd0, 8'd37, 8'd255};
        logic [23:0] rgb[3] = '{24'h000000, 24'h252525, 24'hFFFFFF};
        bit ix, ov, ox, se, sx;
        logic [25:0] obs, e;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cycle(1, 0, lv[k], 2'd0, 1, ix, ov, ox, obs, se, sx);
            for (int j = 1; j <= 3; j++) begin
                cycle(0, 0, 8'h00, 2'd0, 1, ix, ov, ox, obs, se, sx);
                if (j == 1) begin
                    n_tests++;
                    if (ov !== 1'b0) begin n_fail++; $display("FAIL latency_early px%0d: out_valid=%b want 0", k, ov); end
                end
                if (j == 2) begin
                    n_tests++;
                    if (ov !== 1'b1) begin n_fail++; $display("FAIL latency_2 px%0d: out_valid=%b want 1", k, ov); end
                    n_tests++;
                    if (obs[23:0] !== rgb[k]) begin n_fail++; $display("FAIL gray_rgb px%0d: got %h want %h", k, obs[23:0], rgb[k]); end
                end
                if (ox) begin
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : 26'h3FFFFFF;
                    n_tests++;
                    if (obs !== e) begin n_fail++; $display("FAIL gray_model px%0d: got %h want %h", k, obs, e); end
                end
            end
        end
    endtask

    task automatic test_heat();
        bit ix, ov, ox, se, sx;
        logic [25:0] obs, e;
        int idx = 0;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            cycle(c < 2, 0, (c == 0) ? 8'd64 : 8'd200, 2'd2, 1, ix, ov, ox, obs, se, sx);
            if (ox) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 26'h3FFFFFF;
                n_tests++;
                if (obs !== e) begin n_fail++; $display("FAIL heat_model out%0d: got %h want %h", idx, obs, e); end
                if (idx == 1) begin
                    n_tests++;
                    if (obs[23:0] !== 24'h0090FF) begin n_fail++; $display("FAIL heat_200: got %h want 0090ff", obs[23:0]); end
                end
                idx++;
            end
        end
        n_tests++;
        if (idx != 2) begin n_fail++; $display("FAIL heat_count: got %0d outputs want 2", idx); end
    endtask

    task automatic test_frame_markers();
        bit ix, ov, ox, se, sx;
        logic [25:0] obs, e;
        int idx = 0;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            cycle(c < 9, 0, 8'($urandom_range(0, 255)), 2'd0, 1, ix, ov, ox, obs, se, sx);
            if (ox) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 26'h3FFFFFF;
                n_tests++;
                if (obs !== e) begin n_fail++; $display("FAIL frame_model out%0d: got %h want %h", idx, obs, e); end
                n_tests++;
                if (obs[24] !== (idx % 8 == 0) || obs[25] !== (idx % 4 == 3)) begin
                    n_fail++;
                    $display("FAIL frame_markers out%0d: sof=%b eol=%b want sof=%b eol=%b",
                             idx, obs[24], obs[25], (idx % 8 == 0), (idx % 4 == 3));
                end
                idx++;
            end
        end
        n_tests++;
        if (idx != 9) begin n_fail++; $display("FAIL frame_count: got %0d outputs want 9", idx); end
    endtask

    task automatic test_mode_latch();
        bit ix, ov, ox, se, sx;
        logic [25:0] obs, e;
        int idx = 0;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            cycle(c < 16, 0, 8'd130, (c >= 5) ? 2'd1 : 2'd0, 1, ix, ov, ox, obs, se, sx);
            if (ox) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 26'h3FFFFFF;
                n_tests++;
                if (obs[23:0] !== ((idx < 8) ? 24'h828282 : 24'hFFFFFF) || obs !== e) begin
                    n_fail++;
                    $display("FAIL mode_latch out%0d: got %h want rgb %h", idx, obs, (idx < 8) ? 24'h828282 : 24'hFFFFFF);
                end
                idx++;
            end
        end
    endtask

    task automatic test_sync_err();
        bit ix, ov, ox, se, sx;
        logic [25:0] obs, e;
        int idx = 0, pulses = 0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            cycle(c < 6, c == 2, 8'(c * 20), 2'd3, 1, ix, ov, ox, obs, se, sx);
            pulses += se;
            n_tests++;
            if (se !== sx) begin n_fail++; $display("FAIL sync_err cyc%0d: got %b want %b", c, se, sx); end
            if (ox) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 26'h3FFFFFF;
                n_tests++;
                if (obs !== e) begin n_fail++; $display("FAIL sync_model out%0d: got %h want %h", idx, obs, e); end
                if (idx == 2 || idx == 3 || idx == 5) begin
                    n_tests++;
                    if (obs[24] !== (idx == 2) || obs[25] !== (idx == 5)) begin
                        n_fail++;
                        $display("FAIL sync_pos out%0d: sof=%b eol=%b", idx, obs[24], obs[25]);
                    end
                end
                idx++;
            end
        end
        n_tests++;
        if (pulses != 1) begin n_fail++; $display("FAIL sync_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_midreset();
        bit ix, ov, ox, se, sx;
        logic [25:0] obs, e;
        int idx = 0;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            cycle(1, 0, 8'($urandom_range(0, 255)), 2'd0, c != 5, ix, ov, ox, obs, se, sx);
            if (ox) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 26'h3FFFFFF;
                n_tests++;
                if (obs !== e) begin n_fail++; $display("FAIL pre_reset out: got %h want %h", obs, e); end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_flush: out_valid=%b want 0", out_valid); end
        exp_q.delete(); m_pos = 0; m_mode = 0; pend_sync = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 7; c++) begin
            cycle(c < 3, 0, 8'($urandom_range(0, 255)), 2'd1, 1, ix, ov, ox, obs, se, sx);
            if (ox) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 26'h3FFFFFF;
                n_tests++;
                if (obs !== e || (idx == 0 && obs[24] !== 1'b1)) begin
                    n_fail++;
                    $display("FAIL post_reset out%0d: got %h want %h", idx, obs, e);
                end
                idx++;
            end
        end
    endtask

    task automatic test_random_backpressure();
        bit ix, ov, ox, se, sx, v, ordy, prev_stall;
        logic [25:0] obs, e, prev_obs;
        logic [7:0] lv;
        int sent = 0, got = 0, cyc = 0;
        do_reset();
        prev_stall = 1'b0;
        prev_obs = '0;
        lv = 8'($urandom_range(0, 255));
        while ((sent < 1000 || exp_q.size() != 0) && cyc < 20000) begin
            v    = (sent < 1000) && ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 1) == 1) || (sent >= 1000);
            cycle(v, $urandom_range(0, 49) == 0, lv, 2'($urandom_range(0, 3)), ordy, ix, ov, ox, obs, se, sx);
            n_tests++;
            if (se !== sx) begin n_fail++; $display("FAIL rand_sync cyc%0d: got %b want %b", cyc, se, sx); end
            if (prev_stall) begin
                n_tests++;
                if (ov !== 1'b1 || obs !== prev_obs) begin
                    n_fail++;
                    $display("FAIL rand_stall cyc%0d: vld=%b out=%h want vld=1 out=%h", cyc, ov, obs, prev_obs);
                end
            end
            if (ox) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 26'h3FFFFFF;
                n_tests++;
                if (obs !== e) begin n_fail++; $display("FAIL rand_model out%0d: got %h want %h", got, obs, e); end
                got++;
            end
            prev_stall = ov && !ordy;
            prev_obs   = obs;
            if (ix) begin
                sent++;
                lv = 8'($urandom_range(0, 255));
            end
            cyc++;
        end
        n_tests++;
        if (got != 1000 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_count: got %0d outputs (%0d pending) want 1000", got, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_gray_latency();
        test_heat();
        test_frame_markers();
        test_mode_latch();
        test_sync_err();
        test_midreset();
        test_random_backpressure();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
